// File: rtl/axi_lite_bw_master.sv
// ---------------------------------------------------------------------------
// axi_lite_bw_master
//
// AXI4-Lite traffic master for bus-bandwidth measurement. A rising edge on
// INIT_AXI_TXN starts a run of C_NUM_TXN single-beat transactions in one of
// three modes (sampled at start):
//   00 / 11 : write phase, then read phase with data compare
//   01      : write phase only
//   10      : read phase only (no data compare)
// Transaction i targets C_M_TARGET_BASE_ADDR + i*(C_M_AXI_DATA_WIDTH/8).
//
// Optional build macro:
//   AXIL_BW_LFSR_DATA_EN - data pattern is a 32-bit Galois LFSR (taps
//   32,22,2,1, seed 32'hACE1_0001) instead of the incrementing i+1 pattern.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   INIT_AXI_TXN        start request (rising edge detected internally)
//   MODE[1:0]           run mode, latched at start
//   TXN_DONE            high from run end until the next start
//   ERROR               sticky error for the current run
//   ERR_CNT[15:0]       saturating error count
//   CYCLE_CNT[31:0]     saturating count of cycles spent in WRITE/READ
//   M_AXI_*             AXI4-Lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_bw_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = 'h4000_0000,
    parameter int C_NUM_TXN = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            INIT_AXI_TXN,
    input  logic [1:0]                      MODE,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [15:0]                     ERR_CNT,
    output logic [31:0]                     CYCLE_CNT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW_W       = C_M_AXI_ADDR_WIDTH;
    localparam int DW         = C_M_AXI_DATA_WIDTH;
    localparam int ADDR_SHIFT = $clog2(DW / 8);
    localparam int IDX_W      = (C_NUM_TXN > 1) ? $clog2(C_NUM_TXN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_TXN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t             state_q, state_n;
    logic               init_q;
    logic [1:0]         mode_q, mode_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               awvalid_q, awvalid_n;
    logic               wvalid_q, wvalid_n;
    logic               bready_q, bready_n;
    logic               arvalid_q, arvalid_n;
    logic               rready_q, rready_n;
    logic               error_q, error_n;
    logic [15:0]        err_cnt_q, err_cnt_n;
    logic [31:0]        cycle_cnt_q, cycle_cnt_n;
    logic               done_q, done_n;
    logic               err_evt;

    logic               start;
    logic               compare_en;
    logic [AW_W-1:0]    txn_addr;
    logic [DW-1:0]      pattern;

    // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    logic               unused_resp_bits;
    assign unused_resp_bits = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

    assign start      = INIT_AXI_TXN & ~init_q;
    assign compare_en = (mode_q == 2'b00) || (mode_q == 2'b11);
    assign txn_addr   = C_M_TARGET_BASE_ADDR + (AW_W'(idx_q) << ADDR_SHIFT);

`ifdef AXIL_BW_LFSR_DATA_EN
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic [31:0] lfsr_q, lfsr_n, lfsr_adv;

    assign lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    // 64-bit data carries the inverted LFSR word in the upper half.
    if (DW == 64) begin : g_wide_pattern
        assign pattern = {~lfsr_q, lfsr_q};
    end else begin : g_narrow_pattern
        assign pattern = lfsr_q;
    end
`else
    assign pattern = DW'(idx_q) + DW'(1);
`endif

    // Address/data buses are forced to zero while their VALID is low so that
    // every output reads 0 out of reset.
    assign M_AXI_AWADDR  = awvalid_q ? txn_addr : '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wvalid_q ? pattern : '0;
    assign M_AXI_WSTRB   = wvalid_q ? '1 : '0;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = arvalid_q ? txn_addr : '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_CNT       = err_cnt_q;
    assign CYCLE_CNT     = cycle_cnt_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            init_q      <= 1'b0;
            mode_q      <= 2'b00;
            idx_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
`ifdef AXIL_BW_LFSR_DATA_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_n;
            init_q      <= INIT_AXI_TXN;
            mode_q      <= mode_n;
            idx_q       <= idx_n;
            awvalid_q   <= awvalid_n;
            wvalid_q    <= wvalid_n;
            bready_q    <= bready_n;
            arvalid_q   <= arvalid_n;
            rready_q    <= rready_n;
            error_q     <= error_n;
            err_cnt_q   <= err_cnt_n;
            cycle_cnt_q <= cycle_cnt_n;
            done_q      <= done_n;
`ifdef AXIL_BW_LFSR_DATA_EN
            lfsr_q      <= lfsr_n;
`endif
        end
    end

    always_comb begin
        state_n     = state_q;
        mode_n      = mode_q;
        idx_n       = idx_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        bready_n    = bready_q;
        arvalid_n   = arvalid_q;
        rready_n    = rready_q;
        error_n     = error_q;
        err_cnt_n   = err_cnt_q;
        cycle_cnt_n = cycle_cnt_q;
        done_n      = done_q;
        err_evt     = 1'b0;
`ifdef AXIL_BW_LFSR_DATA_EN
        lfsr_n      = lfsr_q;
        if ((state_q == ST_WRITE && wvalid_q && M_AXI_WREADY) ||
            (state_q == ST_READ && rready_q && M_AXI_RVALID)) begin
            lfsr_n = lfsr_adv;
        end
`endif

        if ((state_q == ST_WRITE || state_q == ST_READ) && cycle_cnt_q != '1) begin
            cycle_cnt_n = cycle_cnt_q + 32'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_n      = MODE;
                    idx_n       = '0;
                    error_n     = 1'b0;
                    err_cnt_n   = '0;
                    cycle_cnt_n = '0;
                    done_n      = 1'b0;
`ifdef AXIL_BW_LFSR_DATA_EN
                    lfsr_n      = LFSR_SEED;
`endif
                    if (MODE == 2'b10) begin
                        state_n   = ST_READ;
                        arvalid_n = 1'b1;
                    end else begin
                        state_n   = ST_WRITE;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (bready_q && M_AXI_BVALID) begin
                    bready_n = 1'b0;
                    err_evt  = M_AXI_BRESP[1];
                    if (idx_q == LAST_IDX) begin
                        idx_n = '0;
                        if (mode_q == 2'b01) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n   = ST_READ;
                            arvalid_n = 1'b1;
`ifdef AXIL_BW_LFSR_DATA_EN
                            lfsr_n    = LFSR_SEED;
`endif
                        end
                    end else begin
                        idx_n     = idx_q + IDX_W'(1);
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end
                end else begin
                    // AW and W retire independently; B is only accepted
                    // once both have gone.
                    if (awvalid_q && M_AXI_AWREADY) awvalid_n = 1'b0;
                    if (wvalid_q && M_AXI_WREADY)   wvalid_n  = 1'b0;
                    if (!awvalid_n && !wvalid_n)    bready_n  = 1'b1;
                end
            end

            ST_READ: begin
                if (rready_q && M_AXI_RVALID) begin
                    rready_n = 1'b0;
                    // Response error and miscompare on one beat count once.
                    err_evt  = M_AXI_RRESP[1] | (compare_en && (M_AXI_RDATA != pattern));
                    if (idx_q == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n     = idx_q + IDX_W'(1);
                        arvalid_n = 1'b1;
                    end
                end else begin
                    if (arvalid_q && M_AXI_ARREADY) arvalid_n = 1'b0;
                    if (!arvalid_n)                 rready_n  = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (err_evt) begin
            error_n = 1'b1;
            if (err_cnt_q != '1) err_cnt_n = err_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_lite_bw_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_bw_master
//
// Drives axi_lite_bw_master (default parameters: 32-bit address/data,
// base 0x4000_0000, 16 transactions) against a small AXI4-Lite memory slave
// with programmable ready delays and injectable errors. Expected cycle
// counts, error counts and memory contents come from a transaction-level
// model of the run. Honours AXIL_BW_LFSR_DATA_EN for the data pattern.
// ---------------------------------------------------------------------------
module tb_axi_lite_bw_master;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        ACLK;
    logic        ARESET;
    logic        INIT_AXI_TXN;
    logic [1:0]  MODE;
    logic        TXN_DONE;
    logic        ERROR;
    logic [15:0] ERR_CNT;
    logic [31:0] CYCLE_CNT;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int tests_run;
    int fail_cnt;

    axi_lite_bw_master dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .INIT_AXI_TXN  (INIT_AXI_TXN),
        .MODE          (MODE),
        .TXN_DONE      (TXN_DONE),
        .ERROR         (ERROR),
        .ERR_CNT       (ERR_CNT),
        .CYCLE_CNT     (CYCLE_CNT),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- slave configuration (written by the stimulus) -------
    int aw_delay, w_delay, ar_delay;
    int bresp_err_idx, rd_corrupt_idx, rresp_err_idx;

    // ---------------- memory slave -----------------------------------------
    logic [31:0] mem [0:63];
    int          aw_wait, w_wait, ar_wait;
    logic        got_aw, got_w;
    logic [31:0] aw_addr_q, wdata_q;
    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    assign M_AXI_AWREADY = (aw_wait >= aw_delay);
    assign M_AXI_WREADY  = (w_wait >= w_delay);
    assign M_AXI_ARREADY = (ar_wait >= ar_delay);
    assign M_AXI_BVALID  = bvalid_q;
    assign M_AXI_BRESP   = bresp_q;
    assign M_AXI_RVALID  = rvalid_q;
    assign M_AXI_RRESP   = rresp_q;
    assign M_AXI_RDATA   = rdata_q;

    wire        s_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    wire        s_w_hs  = M_AXI_WVALID & M_AXI_WREADY;
    wire        s_ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    wire        s_b_hs  = M_AXI_BVALID & M_AXI_BREADY;
    wire        s_r_hs  = M_AXI_RVALID & M_AXI_RREADY;
    wire        have_aw = got_aw | s_aw_hs;
    wire        have_w  = got_w | s_w_hs;
    wire [31:0] cur_awaddr = got_aw ? aw_addr_q : M_AXI_AWADDR;
    wire [31:0] cur_wdata  = got_w ? wdata_q : M_AXI_WDATA;
    wire [31:0] w_off = cur_awaddr - BASE;
    wire [31:0] r_off = M_AXI_ARADDR - BASE;
    wire [5:0]  w_slot = w_off[7:2];
    wire [5:0]  r_slot = r_off[7:2];

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_wait   <= 0;
            w_wait    <= 0;
            ar_wait   <= 0;
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
            ar_wait <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_wait + 1 : 0;
            if (s_aw_hs) aw_addr_q <= M_AXI_AWADDR;
            if (s_w_hs)  wdata_q   <= M_AXI_WDATA;
            if (have_aw && have_w && !bvalid_q) begin
                mem[w_slot] <= cur_wdata;
                bvalid_q    <= 1'b1;
                bresp_q     <= (int'(w_slot) == bresp_err_idx) ? 2'b10 : 2'b00;
                got_aw      <= 1'b0;
                got_w       <= 1'b0;
            end else begin
                if (s_aw_hs) got_aw <= 1'b1;
                if (s_w_hs)  got_w  <= 1'b1;
            end
            if (s_b_hs) bvalid_q <= 1'b0;
            if (s_ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= (int'(r_slot) == rd_corrupt_idx) ? 32'h0 : mem[r_slot];
                rresp_q  <= (int'(r_slot) == rresp_err_idx) ? 2'b10 : 2'b00;
            end else if (s_r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Cumulative handshake counters (never reset).
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    always @(posedge ACLK) begin
        if (s_aw_hs) aw_cnt <= aw_cnt + 1;
        if (s_w_hs)  w_cnt  <= w_cnt + 1;
        if (s_b_hs)  b_cnt  <= b_cnt + 1;
        if (s_ar_hs) ar_cnt <= ar_cnt + 1;
        if (s_r_hs)  r_cnt  <= r_cnt + 1;
    end

    // Stalled VALID/READY must hold (and address/data stay stable) until taken.
    int          proto_viol;
    logic        aw_stall, w_stall, ar_stall, b_stall, r_stall;
    logic [31:0] aw_hold, w_hold, ar_hold;
    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_stall <= 1'b0;
            w_stall  <= 1'b0;
            ar_stall <= 1'b0;
            b_stall  <= 1'b0;
            r_stall  <= 1'b0;
        end else begin
            if ((aw_stall && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_hold)) ||
                (w_stall && (!M_AXI_WVALID || M_AXI_WDATA != w_hold)) ||
                (ar_stall && (!M_AXI_ARVALID || M_AXI_ARADDR != ar_hold)) ||
                (b_stall && !M_AXI_BREADY) || (r_stall && !M_AXI_RREADY)) begin
                proto_viol <= proto_viol + 1;
            end
            aw_stall <= M_AXI_AWVALID && !M_AXI_AWREADY;
            w_stall  <= M_AXI_WVALID && !M_AXI_WREADY;
            ar_stall <= M_AXI_ARVALID && !M_AXI_ARREADY;
            b_stall  <= M_AXI_BREADY && !M_AXI_BVALID;
            r_stall  <= M_AXI_RREADY && !M_AXI_RVALID;
            aw_hold  <= M_AXI_AWADDR;
            w_hold   <= M_AXI_WDATA;
            ar_hold  <= M_AXI_ARADDR;
        end
    end

    // ---------------- reference model --------------------------------------
    function automatic logic [31:0] model_pattern(input int i);
        logic [31:0] s;
`ifdef AXIL_BW_LFSR_DATA_EN
        s = 32'hACE1_0001;
        for (int k = 0; k < i; k++) begin
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
`else
        s = 32'(i + 1);
`endif
        return s;
    endfunction

    function automatic bit mode_writes(input int mode);
        return mode != 2;
    endfunction

    function automatic bit mode_reads(input int mode);
        return mode != 1;
    endfunction

    function automatic int model_cycles(input int mode, input int awd, input int wd, input int ard);
        int c;
        c = 0;
        if (mode_writes(mode)) c += N * (((awd > wd) ? awd : wd) + 2);
        if (mode_reads(mode))  c += N * (ard + 2);
        return c;
    endfunction

    function automatic int model_errors(input int mode, input int bidx, input int cidx, input int ridx);
        int  e;
        bit  cmp;
        e   = 0;
        cmp = (mode == 0) || (mode == 3);
        for (int i = 0; i < N; i++) begin
            if (mode_writes(mode) && i == bidx) e++;
            if (mode_reads(mode) && (i == ridx || (cmp && i == cidx))) e++;
        end
        return e;
    endfunction

    // ---------------- checking --------------------------------------------
    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_init(input int mode);
        @(negedge ACLK);
        MODE         = 2'(mode);
        INIT_AXI_TXN = 1'b1;
        @(negedge ACLK);
        INIT_AXI_TXN = 1'b0;
    endtask

    task automatic apply_stimulus(input string tag, input int mode, input int awd, input int wd,
                                  input int ard, input int bidx, input int cidx, input int ridx);
        int  aw0, w0, b0, ar0, r0, viol0;
        int  exp_err, bad_mem;
        bit  saw_error;
        aw_delay       = awd;
        w_delay        = wd;
        ar_delay       = ard;
        bresp_err_idx  = bidx;
        rd_corrupt_idx = cidx;
        rresp_err_idx  = ridx;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; viol0 = proto_viol;
        exp_err = model_errors(mode, bidx, cidx, ridx);

        pulse_init(mode);
        check_output({tag, ".done_clear"}, {TXN_DONE, ERROR, ERR_CNT, CYCLE_CNT}, 64'h0);
        if (mode_writes(mode)) begin
            check_output({tag, ".first_aw"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR},
                         {2'b11, BASE});
            check_output({tag, ".first_wdata"}, {M_AXI_WSTRB, M_AXI_WDATA}, {4'hF, model_pattern(0)});
        end else begin
            check_output({tag, ".first_ar"}, {M_AXI_AWVALID, M_AXI_ARVALID, M_AXI_ARADDR},
                         {2'b01, BASE});
        end

        saw_error = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (TXN_DONE) break;
            if (ERROR) saw_error = 1'b1;
            @(negedge ACLK);
        end
        if (ERROR) saw_error = 1'b1;
        check_output({tag, ".done"}, TXN_DONE, 1'b1);
        check_output({tag, ".cycles"}, CYCLE_CNT, model_cycles(mode, awd, wd, ard));
        check_output({tag, ".err_cnt"}, ERR_CNT, exp_err);
        check_output({tag, ".error"}, {saw_error, ERROR}, {exp_err != 0, exp_err != 0});
        check_output({tag, ".hs_counts"},
                     {aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0, r_cnt - r0},
                     {mode_writes(mode) ? N : 0, mode_writes(mode) ? N : 0, mode_writes(mode) ? N : 0,
                      mode_reads(mode) ? N : 0, mode_reads(mode) ? N : 0});
        check_output({tag, ".protocol"}, proto_viol - viol0, 0);
        if (mode_writes(mode)) begin
            bad_mem = 0;
            for (int i = 0; i < N; i++) begin
                if (mem[i] !== model_pattern(i)) bad_mem++;
            end
            check_output({tag, ".mem"}, bad_mem, 0);
        end
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        tests_run      = 0;
        fail_cnt       = 0;
        ARESET         = 1'b1;
        INIT_AXI_TXN   = 1'b0;
        MODE           = 2'b00;
        aw_delay       = 0;
        w_delay        = 0;
        ar_delay       = 0;
        bresp_err_idx  = -1;
        rd_corrupt_idx = -1;
        rresp_err_idx  = -1;

        #17;
        check_output("reset.status", {TXN_DONE, ERROR, ERR_CNT, CYCLE_CNT}, 64'h0);
        check_output("reset.handshake",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
        check_output("reset.buses", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        apply_stimulus("wr_rd", 0, 0, 0, 0, -1, -1, -1);
        apply_stimulus("wr_only", 1, 0, 0, 0, -1, -1, -1);
        apply_stimulus("rd_only", 2, 0, 0, 0, -1, -1, -1);
        apply_stimulus("errors", 0, 0, 0, 0, 9, 5, -1);
        apply_stimulus("w_late", 1, 0, 3, 0, -1, -1, -1);
        apply_stimulus("mode11", 3, 2, 0, 1, -1, -1, 12);

        // Mid-run reset during write 7, then a clean restart from index 0.
        begin
            int b0;
            aw_delay = 0; w_delay = 0; ar_delay = 0;
            bresp_err_idx = -1; rd_corrupt_idx = -1; rresp_err_idx = -1;
            b0 = b_cnt;
            pulse_init(0);
            for (int c = 0; c < 400; c++) begin
                if (b_cnt - b0 >= 7) break;
                @(negedge ACLK);
            end
            check_output("rst_mid.reach_w7", {M_AXI_AWVALID, 32'(b_cnt - b0)}, {1'b1, 32'd7});
            #2;
            ARESET = 1'b1;
            #1;
            check_output("rst_mid.valids",
                         {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
            check_output("rst_mid.status", {TXN_DONE, ERROR, ERR_CNT, CYCLE_CNT}, 64'h0);
            @(negedge ACLK);
            @(negedge ACLK);
            ARESET = 1'b0;
            @(negedge ACLK);
            check_output("rst_mid.no_done", TXN_DONE, 1'b0);
        end
        apply_stimulus("restart", 0, 0, 0, 0, -1, -1, -1);

        for (int k = 0; k < 5; k++) begin
            int m, awd, wd, ard, bi, ci, ri;
            m   = int'($urandom_range(0, 3));
            awd = int'($urandom_range(0, 3));
            wd  = int'($urandom_range(0, 3));
            ard = int'($urandom_range(0, 3));
            bi  = int'($urandom_range(0, 2 * N));
            ci  = int'($urandom_range(0, 2 * N));
            ri  = int'($urandom_range(0, 2 * N));
            apply_stimulus($sformatf("rand%0d", k), m, awd, wd, ard, bi, ci, ri);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
